// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, reset PC default, fetch
// FSM encoding and the RVC length decode helper.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          HWQ_DEPTH        = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rvc_hw_queue.sv
// Four-entry halfword queue with per-entry PC; pushes and pops of 0/1/2 entries
// per cycle, head and next entries always visible.
module rvc_hw_queue
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [1:0]  push_cnt_i,
  input  logic [15:0] push_data0_i,
  input  logic [31:0] push_pc0_i,
  input  logic [15:0] push_data1_i,
  input  logic [31:0] push_pc1_i,
  input  logic [1:0]  pop_cnt_i,
  output logic [2:0]  count_o,
  output logic [15:0] head_data_o,
  output logic [31:0] head_pc_o,
  output logic [15:0] next_data_o
);

  logic [15:0] data_q [HWQ_DEPTH];
  logic [15:0] data_d [HWQ_DEPTH];
  logic [31:0] pc_q   [HWQ_DEPTH];
  logic [31:0] pc_d   [HWQ_DEPTH];
  logic [2:0]  count_q, count_d;
  logic [2:0]  base;

  // Shift out popped entries first, then append pushes behind the survivors;
  // the caller never pops more than count nor pushes past the depth.
  always_comb begin
    data_d  = data_q;
    pc_d    = pc_q;
    base    = count_q - {1'b0, pop_cnt_i};
    count_d = base + {1'b0, push_cnt_i};
    for (int i = 0; i < HWQ_DEPTH; i++) begin
      for (int j = 0; j < HWQ_DEPTH; j++) begin
        if (j == i + int'(pop_cnt_i)) begin
          data_d[i] = data_q[j];
          pc_d[i]   = pc_q[j];
        end
      end
      if (push_cnt_i != 2'd0 && i == int'(base)) begin
        data_d[i] = push_data0_i;
        pc_d[i]   = push_pc0_i;
      end
      if (push_cnt_i == 2'd2 && i == int'(base) + 1) begin
        data_d[i] = push_data1_i;
        pc_d[i]   = push_pc1_i;
      end
    end
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < HWQ_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = data_q[0];
  assign head_pc_o   = pc_q[0];
  assign next_data_o = data_q[1];

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch front end: word fetches from the I-cache are split into halfwords and
// re-assembled into 16/32-bit instructions for decode.
module rvc_fetch_aligner
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst_ppl,
  output logic [31:0] pc_ppl,
  output logic        compressed_ppl,
  output logic        inst_valid_ppl,
  output logic [1:0]  dbg_fetch_state
);

  fetch_state_e state_q, state_d;
  logic [31:1]  fetch_pc_q, fetch_pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  inst_q, inst_d, pc_q, pc_d;
  logic         comp_q, comp_d, valid_q, valid_d;

  logic [31:0]  word_addr;
  logic         rsp_take, head_rvc, issuable, unused_pc_bit0;
  logic [1:0]   push_cnt, pop_cnt;
  logic [2:0]   q_count;
  logic [15:0]  head_data, next_data;
  logic [31:0]  head_pc;

  assign unused_pc_bit0 = redirect_pc[0];
  assign word_addr      = {fetch_pc_q[31:2], 2'b00};
  // A response is only queued if it belongs to the current fetch stream.
  assign rsp_take       = (state_q == FETCH_WAIT) && rsp_valid && !drop_q && !redirect_valid;
  assign push_cnt       = rsp_take ? (fetch_pc_q[1] ? 2'd1 : 2'd2) : 2'd0;

  rvc_hw_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_cnt_i  (push_cnt),
    .push_data0_i(fetch_pc_q[1] ? rsp_data[31:16] : rsp_data[15:0]),
    .push_pc0_i  (fetch_pc_q[1] ? word_addr + 32'd2 : word_addr),
    .push_data1_i(rsp_data[31:16]),
    .push_pc1_i  (word_addr + 32'd2),
    .pop_cnt_i   (pop_cnt),
    .count_o     (q_count),
    .head_data_o (head_data),
    .head_pc_o   (head_pc),
    .next_data_o (next_data)
  );

  // Request handshake: req_valid/req_addr hold until req_ready is seen with
  // req_valid high; exactly one rsp_valid pulse answers each accepted request.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    case (state_q)
      FETCH_IDLE: if (q_count <= 3'd2) state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (req_ready) begin
          state_d = FETCH_WAIT;
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (rsp_valid) begin
          state_d = FETCH_IDLE;
          drop_d  = 1'b0;
          if (rsp_take) fetch_pc_d = {fetch_pc_q[31:2] + 30'd1, 1'b0};
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc[31:1];
  end

  assign head_rvc = is_rvc(head_data);
  assign issuable = (q_count != 3'd0) && (head_rvc || q_count >= 3'd2);

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    comp_d  = comp_q;
    valid_d = valid_q;
    pop_cnt = 2'd0;
    if (redirect_valid || (!stall && !issuable)) begin
      inst_d  = NOP_INST;
      comp_d  = 1'b0;
      valid_d = 1'b0;
    end else if (!stall) begin
      inst_d  = head_rvc ? {16'h0000, head_data} : {next_data, head_data};
      pc_d    = head_pc;
      comp_d  = head_rvc;
      valid_d = 1'b1;
      pop_cnt = head_rvc ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC[31:1];
      drop_q     <= 1'b0;
      inst_q     <= NOP_INST;
      pc_q       <= '0;
      comp_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      comp_q     <= comp_d;
      valid_q    <= valid_d;
    end
  end

  assign req_valid       = (state_q == FETCH_REQ);
  assign req_addr        = word_addr;
  assign inst_ppl        = inst_q;
  assign pc_ppl          = pc_q;
  assign compressed_ppl  = comp_q;
  assign inst_valid_ppl  = valid_q;
  assign dbg_fetch_state = state_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Bench for rvc_fetch_aligner: behavioural I-cache, table of two-word programs,
// and hand-written redirect / stall / wrap-around sequences.
module tb_rvc_fetch_aligner;
  import riscv_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, rsp_valid, redirect_valid, stall;
  logic        compressed_ppl, inst_valid_ppl;
  logic [31:0] req_addr, rsp_data, redirect_pc, inst_ppl, pc_ppl;
  logic [1:0]  dbg_fetch_state;

  rvc_fetch_aligner dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_ppl       (inst_ppl),
    .pc_ppl         (pc_ppl),
    .compressed_ppl (compressed_ppl),
    .inst_valid_ppl (inst_valid_ppl),
    .dbg_fetch_state(dbg_fetch_state)
  );

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] i0;
    logic [31:0] p0;
    logic        c0;
    logic [31:0] i1;
    logic [31:0] p1;
    logic        c1;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] mem [256];
  logic [64:0] got_q [$];
  logic [64:0] exp_q [$];
  logic [31:0] acc_log [$];
  int          total = 0;
  int          bad = 0;
  bit          pend;
  logic [31:0] pend_addr;
  int          lat, cache_lat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fill_mem();
    for (int k = 0; k < 256; k++) mem[k] = NOP_INST;
  endtask

  // One clock: records what the cache sees before the edge, then updates the
  // cache model and the issue monitor just after it.
  task automatic cycle();
    bit          stall_p, redir_p, rst_p, acc_p;
    logic [31:0] acc_a;
    stall_p = stall;
    redir_p = redirect_valid;
    rst_p   = rst_n;
    acc_p   = (req_valid === 1'b1) && (req_ready === 1'b1);
    acc_a   = req_addr;
    @(posedge clk);
    #1;
    if (!rst_p) begin
      pend      = 1'b0;
      rsp_valid = 1'b0;
    end else begin
      if (rsp_valid) pend = 1'b0;
      if (acc_p) begin
        pend      = 1'b1;
        pend_addr = acc_a;
        lat       = cache_lat;
        acc_log.push_back(acc_a);
      end
      if (pend && lat == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = mem[pend_addr[9:2]];
      end else begin
        rsp_valid = 1'b0;
        if (pend) lat--;
      end
      if (!stall_p && !redir_p && inst_valid_ppl === 1'b1)
        got_q.push_back({compressed_ppl, pc_ppl, inst_ppl});
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_inst", inst_ppl, NOP_INST);
    check("rst_pc", pc_ppl, 32'd0);
    check("rst_comp", 32'(compressed_ppl), 32'd0);
    check("rst_valid", 32'(inst_valid_ppl), 32'd0);
    check("rst_state", 32'(dbg_fetch_state), 32'(FETCH_IDLE));
    rst_n = 1'b1;
    got_q.delete();
    acc_log.delete();
  endtask

  task automatic wait_issues(input int n);
    int c = 0;
    while (got_q.size() < n && c < 300) begin
      cycle();
      c++;
    end
    if (got_q.size() < n) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got %0d issues, need %0d", got_q.size(), n);
    end
  endtask

  // scoreboard: issued instructions against the expected queue, in order
  task automatic compare_issues(input string tag);
    logic [64:0] g, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_missing: no issue, exp pc=%h", tag, e[63:32]);
      end else begin
        g = got_q.pop_front();
        check({tag, "_inst"}, g[31:0], e[31:0]);
        check({tag, "_pc"}, g[63:32], e[63:32]);
        check({tag, "_comp"}, 32'(g[64]), 32'(e[64]));
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    vecs[0] = '{32'h00a0_0093, 32'h0000_0013, 32'h00a0_0093, 32'h0, 1'b0, 32'h0000_0013, 32'h4, 1'b0};
    vecs[1] = '{32'h4501_4501, 32'h0000_0013, 32'h0000_4501, 32'h0, 1'b1, 32'h0000_4501, 32'h2, 1'b1};
    vecs[2] = '{32'h0093_4501, 32'h0000_00a0, 32'h0000_4501, 32'h0, 1'b1, 32'h00a0_0093, 32'h2, 1'b0};
    vecs[3] = '{32'h0001_4581, 32'h0000_0013, 32'h0000_4581, 32'h0, 1'b1, 32'h0000_0001, 32'h2, 1'b1};

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    pend = 1'b0; pend_addr = '0; lat = 0; cache_lat = 0;

    // table-driven programs starting at PC 0
    for (int v = 0; v < 4; v++) begin
      fill_mem();
      mem[0]    = vecs[v].w0;
      mem[1]    = vecs[v].w1;
      cache_lat = v % 2;
      do_reset();
      exp_q.push_back({vecs[v].c0, vecs[v].p0, vecs[v].i0});
      exp_q.push_back({vecs[v].c1, vecs[v].p1, vecs[v].i1});
      wait_issues(2);
      compare_issues($sformatf("vec%0d", v));
    end

    // redirect while the first request is outstanding
    fill_mem();
    mem[0]    = 32'h4581_4581;
    mem[65]   = 32'h4501_0000;
    mem[66]   = 32'h00a0_0093;
    cache_lat = 2;
    do_reset();
    c = 0;
    while (acc_log.size() == 0 && c < 20) begin
      cycle();
      c++;
    end
    check("redir_first_req", (acc_log.size() > 0) ? acc_log[0] : 32'hdead_beef, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0106;
    cycle();
    redirect_valid = 1'b0;
    check("redir_bubble_valid", 32'(inst_valid_ppl), 32'd0);
    check("redir_bubble_inst", inst_ppl, NOP_INST);
    got_q.delete();
    acc_log.delete();
    exp_q.push_back({1'b1, 32'h0000_0106, 32'h0000_4501});
    exp_q.push_back({1'b0, 32'h0000_0108, 32'h00a0_0093});
    wait_issues(2);
    check("redir_req_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hdead_beef, 32'h104);
    compare_issues("redir");

    // stall with a full queue, then a single-issue release inside the stall
    fill_mem();
    mem[0]    = 32'h4501_4501;
    mem[1]    = 32'h00a0_0093;
    mem[2]    = 32'h4581_4581;
    cache_lat = 0;
    stall     = 1'b1;
    do_reset();
    repeat (15) cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("stall_full_req", 32'(req_valid), 32'd0);
      check("stall_full_valid", 32'(inst_valid_ppl), 32'd0);
      check("stall_full_inst", inst_ppl, NOP_INST);
    end
    stall = 1'b0;
    cycle();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("stall_hold_inst", inst_ppl, 32'h0000_4501);
      check("stall_hold_pc", pc_ppl, 32'h0);
      check("stall_hold_valid", 32'(inst_valid_ppl), 32'd1);
      check("stall_hold_req", 32'(req_valid), 32'd0);
    end
    stall = 1'b0;
    exp_q.push_back({1'b1, 32'h0, 32'h0000_4501});
    exp_q.push_back({1'b1, 32'h2, 32'h0000_4501});
    exp_q.push_back({1'b0, 32'h4, 32'h00a0_0093});
    exp_q.push_back({1'b1, 32'h8, 32'h0000_4581});
    exp_q.push_back({1'b1, 32'ha, 32'h0000_4581});
    wait_issues(5);
    compare_issues("stall");

    // redirect on the response cycle, to the last halfword of the address space
    mem[255]  = 32'h4581_0000;
    cache_lat = 1;
    c = 0;
    while (rsp_valid !== 1'b1 && c < 50) begin
      cycle();
      c++;
    end
    if (rsp_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wrap_rsp_timeout: no response within %0d cycles", c);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_ffff;
    cycle();
    redirect_valid = 1'b0;
    got_q.delete();
    exp_q.push_back({1'b1, 32'hffff_fffe, 32'h0000_4581});
    exp_q.push_back({1'b1, 32'h0000_0000, 32'h0000_4501});
    wait_issues(2);
    compare_issues("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
